// File: rtl/qpsk_tx_encoder.sv
// qpsk_tx_encoder: (8,4) block encoder with a one-word pending buffer and a 2-bit QPSK symbol serializer
module qpsk_tx_encoder #(
  parameter bit PARITY0 = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] sym_out,
  output logic       mod_en,
  input  logic       mod_ready,
  output logic       sym_first,
  output logic       busy
);
  localparam logic IDLE = 1'b0;
  localparam logic SEND = 1'b1;

  logic       state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [3:0] pend_q, pend_d;
  logic       pv_q, pv_d;
  logic       accept, xfer, load;

  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [7:1] c;
    c = {d[3] ^ d[1] ^ d[0], d[3] ^ d[2] ^ d[1], d[3] ^ d[1] ^ d[0], d[0], d[1], d[2], d[3]};
    c[7] = d[2] ^ d[1] ^ d[0];
    return {c, PARITY0 ? ^c : 1'b0};
  endfunction

  assign in_ready  = !pv_q;
  assign accept    = in_valid & !pv_q;
  assign mod_en    = state_q == SEND;
  assign xfer      = mod_en & mod_ready;
  // A load happens whenever the shifter is free: idle, or the last symbol is leaving now.
  assign load      = !mod_en | (xfer & cnt_q == 2'd3);
  assign sym_out   = sh_q[1:0];
  assign sym_first = mod_en & cnt_q == 2'd0;
  assign busy      = mod_en | pv_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    pend_d  = pend_q;
    pv_d    = pv_q;
    if (load) begin
      state_d = (pv_q | accept) ? SEND : IDLE;
      cnt_d   = 2'd0;
      sh_d    = pv_q ? enc(pend_q) : accept ? enc(data_in) : sh_q;
      pv_d    = 1'b0;
    end else begin
      sh_d   = xfer ? {2'b00, sh_q[7:2]} : sh_q;
      cnt_d  = xfer ? cnt_q + 2'd1 : cnt_q;
      pv_d   = pv_q | accept;
      pend_d = accept ? data_in : pend_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      sh_q    <= 8'h00;
      pend_q  <= 4'h0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      pend_q  <= pend_d;
      pv_q    <= pv_d;
    end
  end
endmodule

// File: tb/tb_qpsk_tx_encoder.sv
// tb_qpsk_tx_encoder: directed checks of encoding, serialization, backpressure, reset and decoder loopback
module tb_qpsk_tx_encoder;
  logic       clk = 1'b0, reset = 1'b1, in_valid = 1'b0, mod_ready = 1'b1;
  logic [3:0] data_in = 4'h0;
  logic       in_ready, mod_en, sym_first, busy;
  logic [1:0] sym_out;
  logic       in_ready1, mod_en1, sym_first1, busy1;
  logic [1:0] sym_out1;
  int         total = 0, bad = 0;
  logic [1:0] s0 [16];
  logic [1:0] s1 [16];
  logic       f0 [16];
  int         n;

  qpsk_tx_encoder #(.PARITY0(1'b1)) u0 (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .sym_out(sym_out), .mod_en(mod_en), .mod_ready(mod_ready), .sym_first(sym_first), .busy(busy)
  );
  qpsk_tx_encoder #(.PARITY0(1'b0)) u1 (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready1),
    .sym_out(sym_out1), .mod_en(mod_en1), .mod_ready(mod_ready), .sym_first(sym_first1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] cw0();
    return {s0[3], s0[2], s0[1], s0[0]};
  endfunction

  function automatic logic [7:0] cw1();
    return {s1[3], s1[2], s1[1], s1[0]};
  endfunction

  // Syndrome decoder matching the receiver's check matrix; corrects one error on c1..c4.
  function automatic logic [3:0] decode(input logic [7:0] c);
    logic [2:0] syn;
    logic [7:0] x;
    x = c;
    syn = {c[7] ^ c[2] ^ c[3] ^ c[4], c[6] ^ c[1] ^ c[2] ^ c[3], c[5] ^ c[1] ^ c[3] ^ c[4]};
    if (syn == 3'b011) x[1] = ~x[1];
    if (syn == 3'b110) x[2] = ~x[2];
    if (syn == 3'b111) x[3] = ~x[3];
    if (syn == 3'b101) x[4] = ~x[4];
    return {x[1], x[2], x[3], x[4]};
  endfunction

  task automatic collect(input logic [3:0] d);
    in_valid = 1'b1;
    data_in  = d;
    tick();
    in_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && (mod_en || n == 0); c++) begin
      if (mod_en && n < 16) begin
        s0[n] = sym_out;
        s1[n] = sym_out1;
        f0[n] = sym_first;
        n++;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    total += 5;
    if (sym_out !== 2'b00) begin bad++; $display("FAIL reset_sym_out got=%b exp=00", sym_out); end
    if (mod_en !== 1'b0) begin bad++; $display("FAIL reset_mod_en got=%b exp=0", mod_en); end
    if (sym_first !== 1'b0) begin bad++; $display("FAIL reset_sym_first got=%b exp=0", sym_first); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    collect(4'b1011);
    total += 4;
    if (n !== 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", n); end
    if (cw0() !== 8'h3A) begin bad++; $display("FAIL basic_codeword got=%h exp=3a", cw0()); end
    if ({f0[0], f0[1], f0[2], f0[3]} !== 4'b1000)
      begin bad++; $display("FAIL basic_sym_first got=%b%b%b%b exp=1000", f0[0], f0[1], f0[2], f0[3]); end
    if (mod_en !== 1'b0) begin bad++; $display("FAIL basic_idle_after got=%b exp=0", mod_en); end
  endtask

  task automatic test_parity0;
    collect(4'b1111);
    total += 2;
    if (cw1() !== 8'hFE) begin bad++; $display("FAIL parity0_off_codeword got=%h exp=fe", cw1()); end
    if (cw0() !== 8'hFF) begin bad++; $display("FAIL parity0_on_codeword got=%h exp=ff", cw0()); end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  w [3];
    logic [23:0] got;
    int idx, cnt, first, last, low;
    logic acc;
    w[0] = 4'b0001; w[1] = 4'b1111; w[2] = 4'b0000;
    idx = 0; cnt = 0; first = -1; last = -1; low = 0; got = '0;
    mod_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_valid = idx < 3;
      data_in  = (idx < 3) ? w[idx] : 4'h0;
      acc = in_valid & in_ready;
      tick();
      if (acc) idx++;
      if (mod_en && cnt < 12) begin
        got = {got[21:0], sym_out};
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
      if (!in_ready) low++;
    end
    in_valid = 1'b0;
    total += 3;
    if (got !== 24'b01_00_11_10_11_11_11_11_00_00_00_00)
      begin bad++; $display("FAIL b2b_symbols got=%h exp=%h", got, 24'b01_00_11_10_11_11_11_11_00_00_00_00); end
    if (cnt !== 12 || last - first !== 11)
      begin bad++; $display("FAIL b2b_contiguous got count=%0d span=%0d exp count=12 span=11", cnt, last - first); end
    if (low !== 6) begin bad++; $display("FAIL b2b_in_ready_low got=%0d exp=6", low); end
  endtask

  task automatic test_stall;
    int held_bad;
    held_bad = 0;
    in_valid = 1'b1;
    data_in  = 4'b1011;
    tick();
    in_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && (mod_en || n == 0); c++) begin
      if (mod_en && n < 16) begin
        s0[n] = sym_out;
        n++;
        if (n == 3) begin
          mod_ready = 1'b0;
          for (int k = 0; k < 5; k++) begin
            tick();
            if (sym_out !== 2'b11 || mod_en !== 1'b1 || sym_first !== 1'b0) held_bad++;
          end
          mod_ready = 1'b1;
        end
      end
      tick();
    end
    total += 3;
    if (held_bad !== 0) begin bad++; $display("FAIL stall_hold got=%0d unstable cycles exp=0", held_bad); end
    if (n !== 4) begin bad++; $display("FAIL stall_count got=%0d exp=4", n); end
    if (cw0() !== 8'h3A) begin bad++; $display("FAIL stall_codeword got=%h exp=3a", cw0()); end
  endtask

  task automatic test_reset_mid;
    mod_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = 4'b1011;
    tick();
    data_in = 4'b0001;
    tick();
    in_valid = 1'b0;
    total += 3;
    if (sym_out !== 2'b10) begin bad++; $display("FAIL mid_sym1 got=%b exp=10", sym_out); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_pending_in_ready got=%b exp=0", in_ready); end
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total += 3;
    if (mod_en !== 1'b0) begin bad++; $display("FAIL mid_reset_mod_en got=%b exp=0", mod_en); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_in_ready got=%b exp=1", in_ready); end
    collect(4'b0001);
    total += 3;
    if (n !== 4) begin bad++; $display("FAIL mid_new_count got=%0d exp=4", n); end
    if (s0[0] !== 2'b01 || f0[0] !== 1'b1)
      begin bad++; $display("FAIL mid_new_first got sym=%b first=%b exp sym=01 first=1", s0[0], f0[0]); end
    if (cw0() !== 8'hB1) begin bad++; $display("FAIL mid_new_codeword got=%h exp=b1", cw0()); end
  endtask

  task automatic test_loopback;
    logic [7:0] c, e;
    logic [3:0] dec;
    for (int d = 0; d < 16; d++) begin
      collect(d[3:0]);
      c = cw0();
      total += 2;
      if (n !== 4 || ^c !== 1'b0) begin bad++; $display("FAIL loop_even_parity d=%0d got count=%0d cw=%h", d, n, c); end
      if (cw1() !== {c[7:1], 1'b0}) begin bad++; $display("FAIL loop_p0off d=%0d got=%h exp=%h", d, cw1(), {c[7:1], 1'b0}); end
      for (int b = 1; b <= 4; b++) begin
        e = c ^ (8'h01 << b);
        dec = decode(e);
        total++;
        if (dec !== d[3:0]) begin bad++; $display("FAIL loop_decode d=%0d err_bit=%0d got=%h exp=%h", d, b, dec, d[3:0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity0();
    test_back_to_back();
    tick();
    test_stall();
    test_reset_mid();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
